// File: rtl/apb_gpio_if.sv
// APB3 slave front end for the GPIO register block: one wait state on reads, zero on writes.
// Optional macro GPIO_APB_PSLVERR_EN turns out-of-map accesses into PSLVERR responses.
module apb_gpio_if #(
    parameter logic [31:0] LAST_ADDR = 32'h24
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [31:0] gpio_addr,
    output logic        gpio_we,
    output logic [31:0] gpio_dat_i,
    input  logic [31:0] gpio_dat_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_ACC  = 3'd1,
        R_WAIT = 3'd2,
        R_ACC  = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        pready_q, pready_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        addrLegal;
    logic        setupPhase;
    logic        accessOk;

`ifdef GPIO_APB_PSLVERR_EN
    logic        pslverr_q, pslverr_d;
`endif

    assign addrLegal  = (paddr[1:0] == 2'b00) && (paddr <= LAST_ADDR);
    assign setupPhase = psel && !penable;
    assign accessOk   = psel && penable;

    always_comb begin
        state_d  = state_q;
        pready_d = 1'b0;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
`ifdef GPIO_APB_PSLVERR_EN
        pslverr_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (setupPhase) begin
                    addr_d = paddr;
                    if (pwrite) begin
                        wdat_d = pwdata;
                    end
`ifdef GPIO_APB_PSLVERR_EN
                    if (!addrLegal) begin
                        state_d   = ERR;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else if (pwrite) begin
                        state_d  = W_ACC;
                        pready_d = 1'b1;
                        we_d     = 1'b1;
                    end else begin
                        state_d = R_WAIT;
                    end
`else
                    // Without error responses an illegal write still completes, just silently dropped.
                    if (pwrite) begin
                        state_d  = W_ACC;
                        pready_d = 1'b1;
                        we_d     = addrLegal;
                    end else begin
                        state_d = R_WAIT;
                    end
`endif
                end
            end
            R_WAIT: begin
                if (accessOk) begin
                    state_d  = R_ACC;
                    pready_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            W_ACC, R_ACC, ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            pready_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdat_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            pready_q <= pready_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
        end
    end

`ifdef GPIO_APB_PSLVERR_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= pslverr_d;
        end
    end
    assign pslverr = pslverr_q;
`else
    assign pslverr = 1'b0;
`endif

    // An access phase dropped mid-write must not reach the register block.
    assign gpio_we    = we_q && (state_q == W_ACC) && accessOk;
    assign pready     = pready_q;
    assign prdata     = (state_q == R_ACC) ? gpio_dat_o : 32'h0;
    assign gpio_addr  = addr_q;
    assign gpio_dat_i = wdat_q;

endmodule

// File: tb/tb_apb_gpio_if.sv
// Directed scoreboard bench for apb_gpio_if with a simple registered GPIO register-file model.
// Honours GPIO_APB_PSLVERR_EN when computing expected error responses.
module tb_apb_gpio_if;

    localparam logic [31:0] LAST = 32'h24;
`ifdef GPIO_APB_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] gpio_addr;
    logic        gpio_we;
    logic [31:0] gpio_dat_i;
    logic [31:0] gpioDatO = 32'h0;

    logic [31:0] regFile [0:15];
    logic [31:0] expMem  [0:15];

    int total = 0;
    int bad = 0;
    int weSeen = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        we;
        logic [3:0]  waits;
    } sbEntry_t;

    sbEntry_t sbQ[$];

    apb_gpio_if #(.LAST_ADDR(LAST)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .gpio_addr (gpio_addr),
        .gpio_we   (gpio_we),
        .gpio_dat_i(gpio_dat_i),
        .gpio_dat_o(gpioDatO)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic mapped(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a <= LAST);
    endfunction

    // Register block model: writes on gpio_we, read data registered one cycle after the address.
    always @(posedge sys_clk) begin
        if (gpio_we === 1'b1 && mapped(gpio_addr) === 1'b1) begin
            regFile[gpio_addr[5:2]] <= gpio_dat_i;
        end
        gpioDatO <= (mapped(gpio_addr) === 1'b1) ? regFile[gpio_addr[5:2]] : 32'h0;
    end

    always @(negedge sys_clk) begin
        if (gpio_we === 1'b1) begin
            weSeen++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One complete APB transfer; expectations are queued at drive time and popped at pready.
    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                 input logic idleAfter, input string tag);
        sbEntry_t e;
        sbEntry_t got;
        int       waits;
        int       weBefore;
        logic     legal;
        legal   = mapped(a);
        e.err   = ERR_EN && !legal;
        e.we    = wr && legal;
        e.waits = (wr || e.err) ? 4'd0 : 4'd1;
        e.data  = (!wr && legal) ? expMem[a[5:2]] : 32'h0;
        if (wr && legal) begin
            expMem[a[5:2]] = d;
        end
        sbQ.push_back(e);
        weBefore = weSeen;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge sys_clk); #1;
        penable = 1'b1;
        @(negedge sys_clk);
        checkOutput({tag, "_addr"}, gpio_addr, a);
        if (wr) begin
            checkOutput({tag, "_wdat"}, gpio_dat_i, d);
        end
        checkOutput({tag, "_we"}, {31'b0, gpio_we}, {31'b0, e.we});
        waits = 0;
        while (pready !== 1'b1 && waits < 4) begin
            @(negedge sys_clk);
            waits++;
        end
        got = sbQ.pop_front();
        checkOutput({tag, "_waits"}, waits, {28'b0, got.waits});
        checkOutput({tag, "_rdy"}, {31'b0, pready}, 32'h1);
        if (!wr || got.err) begin
            checkOutput({tag, "_prdata"}, prdata, got.data);
        end
        checkOutput({tag, "_slverr"}, {31'b0, pslverr}, {31'b0, got.err});
        @(posedge sys_clk); #1;
        checkOutput({tag, "_wecount"}, weSeen - weBefore, {31'b0, got.we});
        if (idleAfter) begin
            psel = 1'b0;
            penable = 1'b0;
        end
    endtask

    initial begin
        int weBefore;
        for (int i = 0; i < 16; i++) begin
            regFile[i] = 32'h0;
            expMem[i]  = 32'h0;
        end

        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        checkOutput("rst_pready", {31'b0, pready}, 32'h0);
        checkOutput("rst_pslverr", {31'b0, pslverr}, 32'h0);
        checkOutput("rst_we", {31'b0, gpio_we}, 32'h0);
        checkOutput("rst_prdata", prdata, 32'h0);
        checkOutput("rst_addr", gpio_addr, 32'h0);
        checkOutput("rst_wdat", gpio_dat_i, 32'h0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        applyStimulus(1'b1, 32'h4,  32'hA5A5_0F0F, 1'b1, "wr4");
        applyStimulus(1'b0, 32'h4,  32'h0,         1'b1, "rd4");
        applyStimulus(1'b1, 32'h0,  32'hDEAD_BEEF, 1'b1, "wr0");
        applyStimulus(1'b1, 32'h24, 32'h1357_2468, 1'b1, "wr24");
        applyStimulus(1'b0, 32'h24, 32'h0,         1'b1, "rd24");
        applyStimulus(1'b1, 32'h28, 32'h5555_AAAA, 1'b1, "wr28bad");
        applyStimulus(1'b0, 32'h6,  32'h0,         1'b1, "rd6bad");
        applyStimulus(1'b1, 32'h8,  32'hFFFF_0000, 1'b0, "b2bwr8");
        applyStimulus(1'b0, 32'h8,  32'h0,         1'b1, "b2brd8");

        // Write whose access phase never comes: penable stays low in T1.
        weBefore = weSeen;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h1234_5678;
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        checkOutput("abort_we", {31'b0, gpio_we}, 32'h0);
        @(posedge sys_clk); #1;
        psel = 1'b0;
        @(negedge sys_clk);
        checkOutput("abort_idle_rdy", {31'b0, pready}, 32'h0);
        checkOutput("abort_wecount", weSeen - weBefore, 32'h0);
        @(posedge sys_clk); #1;
        applyStimulus(1'b0, 32'h4, 32'h0, 1'b1, "abort_rd4");

        // Reset while the read sits in its wait state.
        weBefore = weSeen;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
        @(posedge sys_clk); #1;
        penable = 1'b1;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        checkOutput("rwait_rdy", {31'b0, pready}, 32'h0);
        @(posedge sys_clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge sys_clk);
        checkOutput("midrst_pready", {31'b0, pready}, 32'h0);
        checkOutput("midrst_pslverr", {31'b0, pslverr}, 32'h0);
        checkOutput("midrst_we", {31'b0, gpio_we}, 32'h0);
        checkOutput("midrst_prdata", prdata, 32'h0);
        checkOutput("midrst_addr", gpio_addr, 32'h0);
        checkOutput("midrst_wdat", gpio_dat_i, 32'h0);
        checkOutput("midrst_wecount", weSeen - weBefore, 32'h0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, "postrst_rd0");

        repeat (2) @(posedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
